// File: rtl/strip_conv_scheduler_if.sv
// Handshake bundle between the strip scheduler, the strip engines and the UART reader.
// The scheduler takes the master side; the engines, the reader and the frame controller take the slave side.
interface strip_conv_scheduler_if #(
    parameter int NUM_STRIPS = 8
);
    logic                  go;
    logic [NUM_STRIPS-1:0] strip_start;
    logic [NUM_STRIPS-1:0] strip_done;
    logic                  reader_start;
    logic                  reader_done;
    logic                  busy;
    logic [NUM_STRIPS-1:0] active_mask;
    logic [NUM_STRIPS-1:0] done_mask;
    logic                  frame_done;
    logic                  error;

    modport master (
        input  go, strip_done, reader_done,
        output strip_start, reader_start, busy, active_mask, done_mask, frame_done, error
    );

    modport slave (
        output go, strip_done, reader_done,
        input  strip_start, reader_start, busy, active_mask, done_mask, frame_done, error
    );
endinterface

// File: rtl/strip_conv_scheduler.sv
// Issues strips 0..NUM_STRIPS-1 with at most MAX_ACTIVE in flight and retires them on done pulses.
// After all strips are retired it starts UART readback; a watchdog aborts a stalled frame.
module strip_conv_scheduler #(
    parameter int          NUM_STRIPS = 8,
    parameter int          MAX_ACTIVE = 2,
    parameter logic [23:0] TIMEOUT    = 24'd2000000
) (
    input logic clk,
    input logic reset,
    strip_conv_scheduler_if.master bus
);
    localparam int NS_W = $clog2(NUM_STRIPS + 1);

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        READOUT,
        FINISH,
        ABORT
    } state_t;

    state_t                state;
    logic [NS_W-1:0]       next_strip;
    logic [23:0]           wdog;
    logic                  phase;
    logic [NS_W-1:0]       in_flight;
    logic                  can_issue;
    logic [NUM_STRIPS-1:0] start_vec;
    logic [NUM_STRIPS-1:0] retire;
    logic [NUM_STRIPS-1:0] active_nxt;
    logic [NUM_STRIPS-1:0] done_nxt;

    // A done arriving while its own start pulse is still out is not a valid retirement.
    always_comb begin
        retire     = bus.strip_done & bus.active_mask & ~bus.strip_start;
        active_nxt = bus.active_mask & ~retire;
        done_nxt   = bus.done_mask | retire;
        in_flight  = NS_W'($countones(bus.active_mask));
        can_issue  = (next_strip < NS_W'(NUM_STRIPS)) && (in_flight < NS_W'(MAX_ACTIVE));
        start_vec  = NUM_STRIPS'(1) << next_strip;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            next_strip       <= '0;
            wdog             <= '0;
            phase            <= 1'b0;
            bus.strip_start  <= '0;
            bus.reader_start <= 1'b0;
            bus.busy         <= 1'b0;
            bus.active_mask  <= '0;
            bus.done_mask    <= '0;
            bus.frame_done   <= 1'b0;
            bus.error        <= 1'b0;
        end else begin
            bus.strip_start  <= '0;
            bus.reader_start <= 1'b0;
            bus.frame_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        bus.done_mask   <= '0;
                        bus.active_mask <= '0;
                        bus.error       <= 1'b0;
                        next_strip      <= '0;
                        wdog            <= '0;
                        phase           <= 1'b0;
                        bus.busy        <= 1'b1;
                        state           <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (&done_nxt) begin
                        bus.active_mask <= active_nxt;
                        bus.done_mask   <= done_nxt;
                        wdog            <= '0;
                        phase           <= 1'b0;
                        state           <= READOUT;
                    end else if (retire == '0 && bus.active_mask != '0 &&
                                 wdog == TIMEOUT - 24'd1) begin
                        // done_mask is left untouched so the stalled strips can be identified.
                        bus.error       <= 1'b1;
                        bus.active_mask <= '0;
                        state           <= ABORT;
                    end else begin
                        bus.done_mask <= done_nxt;
                        if (can_issue) begin
                            bus.strip_start <= start_vec;
                            bus.active_mask <= active_nxt | start_vec;
                            next_strip      <= next_strip + NS_W'(1);
                        end else begin
                            bus.active_mask <= active_nxt;
                        end
                        if (retire != '0) begin
                            wdog <= '0;
                        end else if (bus.active_mask != '0) begin
                            wdog <= wdog + 24'd1;
                        end
                    end
                end
                READOUT: begin
                    // First cycle fires the reader; afterwards wait for its completion.
                    if (!phase) begin
                        bus.reader_start <= 1'b1;
                        phase            <= 1'b1;
                    end else if (bus.reader_done) begin
                        phase <= 1'b0;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    if (!phase) begin
                        bus.frame_done <= 1'b1;
                        phase          <= 1'b1;
                    end else begin
                        phase    <= 1'b0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                ABORT: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
